pipe_addsub: RTL and testbench

Pipelined, parametrised add/subtract unit with valid/ready handshakes on input and output. It generalises the single-cycle `adder` / `four_adder` datapath. The carry chain is split into `STAGES` registered slices, and each result carries carry, signed-overflow and zero flags. It sits between the issue logic and the writeback mux of the CPU pipeline, and is also used for address generation next to the cache. The block absorbs output backpressure without losing or duplicating results.

---
 rtl/pipe_addsub.sv | 112 +++++++++++
 tb/tb_pipe_addsub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES registered slices,
// with valid/ready handshakes and carry / signed-overflow / zero flags on the result.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int SW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > 4 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_addsub: STAGES must be 1..4 and divide WIDTH");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
    // The pipeline advances as a whole whenever the last stage is empty or being popped.

    logic [STAGES:1]            r_v;
    logic [STAGES:1][WIDTH-1:0] r_a;
    logic [STAGES:1][WIDTH-1:0] r_b;
    logic [STAGES:1][WIDTH-1:0] r_sum;
    logic [STAGES:1]            r_c;
    logic                       r_ovf;

    logic                       w_adv;
    logic [STAGES:1]            w_src_v;
    logic [STAGES:1]            w_src_c;
    logic [STAGES:1][WIDTH-1:0] w_src_a;
    logic [STAGES:1][WIDTH-1:0] w_src_b;
    logic [STAGES:1][WIDTH-1:0] w_src_sum;
    logic [STAGES:1][WIDTH-1:0] w_nxt_sum;
    logic [STAGES:1][SW:0]      w_slice;
    logic                       w_c_msb;
    logic                       w_nxt_ovf;

    always_comb begin
        w_adv     = !r_v[STAGES] || out_ready;
        w_src_v   = '0;
        w_src_c   = '0;
        w_src_a   = '0;
        w_src_b   = '0;
        w_src_sum = '0;
        w_nxt_sum = '0;
        w_slice   = '0;

        // Stage 1 is fed from the ports; subtract is a + ~b + 1.
        w_src_v[1] = in_valid && w_adv;
        w_src_a[1] = in_a;
        w_src_b[1] = in_sub ? ~in_b : in_b;
        w_src_c[1] = in_sub;
        for (int k = 2; k <= STAGES; k++) begin
            w_src_v[k]   = r_v[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_c[k]   = r_c[k-1];
            w_src_sum[k] = r_sum[k-1];
        end

        for (int k = 1; k <= STAGES; k++) begin
            w_slice[k] = {1'b0, w_src_a[k][(k-1)*SW +: SW]}
                       + {1'b0, w_src_b[k][(k-1)*SW +: SW]}
                       + {{SW{1'b0}}, w_src_c[k]};
            w_nxt_sum[k] = w_src_sum[k];
            w_nxt_sum[k][(k-1)*SW +: SW] = w_slice[k][SW-1:0];
        end

        // The carry into the MSB is recovered from the MSB sum bit and its operands.
        w_c_msb   = w_src_a[STAGES][WIDTH-1] ^ w_src_b[STAGES][WIDTH-1]
                  ^ w_slice[STAGES][SW-1];
        w_nxt_ovf = w_c_msb ^ w_slice[STAGES][SW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v   <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_v   <= w_src_v;
            r_a   <= w_src_a;
            r_b   <= w_src_b;
            r_sum <= w_nxt_sum;
            for (int k = 1; k <= STAGES; k++) begin
                r_c[k] <= w_slice[k][SW];
            end
            r_ovf <= w_nxt_ovf;
        end
    end

    assign in_ready  = w_adv;
    assign out_valid = r_v[STAGES];
    assign out_sum   = r_sum[STAGES];
    assign out_cout  = r_c[STAGES];
    assign out_ovf   = r_ovf;
    assign out_zero  = (r_sum[STAGES] == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed corner cases with literal results,
// backpressure, mid-flight reset and a randomized run against a plain-arithmetic model.
module tb_pipe_addsub;
    localparam int W  = 32;
    localparam int ST = 2;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int n_checks = 0;
    int n_pass   = 0;
    int n_pops   = 0;
    logic [W+2:0] exp_q[$];

    pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // {cout, ovf, zero, sum} from plain unsigned/signed arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic [W:0] r;
        logic       ovf;
        if (!sub) begin
            r   = {1'b0, a} + {1'b0, b};
            ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        end else begin
            r[W-1:0] = a - b;
            r[W]     = (a >= b);
            ovf      = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        end
        return {r[W], ovf, (r[W-1:0] == '0), r[W-1:0]};
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'h0000_0001;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h7FFF_FFFF;
            4:       v = 32'h8000_0000;
            5:       v = 32'h0000_FFFF;
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    initial begin
        logic         st_prev;
        logic [W+2:0] st_val;
        logic [W+2:0] e;
        st_prev = 1'b0;
        st_val  = '0;
        forever begin
            @(negedge clk);
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (st_prev) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", {out_cout, out_ovf, out_zero, out_sum}, st_val);
            end
            if (rst) begin
                exp_q.delete();
                st_prev = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("pop_expected", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", {out_cout, out_ovf, out_zero, out_sum}, e);
                        n_pops++;
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub));
                st_prev = out_valid && !out_ready;
                st_val  = {out_cout, out_ovf, out_zero, out_sum};
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] e_sum, input logic e_c, input logic e_o,
                         input logic e_z);
        int cyc;
        in_a      = a;
        in_b      = b;
        in_sub    = sub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1 chk("op_in_ready", in_ready, 1'b1);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            cyc++;
            if (out_valid) break;
        end
        chk("op_latency", cyc, ST);
        chk("op_sum", out_sum, e_sum);
        chk("op_cout", out_cout, e_c);
        chk("op_ovf", out_ovf, e_o);
        chk("op_zero", out_zero, e_z);
        @(posedge clk); #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int  base;
        int  i;
        logic acc;

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_zero", out_zero, 1'b1);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_cout", out_cout, 1'b0);
        chk("rst_out_ovf", out_ovf, 1'b0);

        // Directed corner cases with hand-computed results.
        do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
        do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        do_op(32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

        // Backpressure: 6 ops a=i, b=100 with out_ready cycling 1,0,0.
        base = n_pops;
        i    = 0;
        for (int c = 0; c < 60 && (i < 6 || exp_q.size() != 0); c++) begin
            in_valid  = (i < 6);
            in_a      = W'(i);
            in_b      = 32'd100;
            in_sub    = 1'b0;
            out_ready = (c % 3 == 0);
            #1 acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) i++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("bp_accepted", i, 6);
        chk("bp_pops", n_pops - base, 6);
        chk("bp_drained", exp_q.size(), 0);

        // Mid-flight reset: the in-flight op and the op offered with rst must vanish.
        out_ready = 1'b1;
        in_valid  = 1'b1; in_a = 32'd10; in_b = 32'd20; in_sub = 1'b0;
        @(posedge clk); #1;
        in_a = 32'd30; in_b = 32'd40; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("flush_valid_now", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("flush_no_valid", out_valid, 1'b0);
        end
        do_op(32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with random backpressure.
        base = n_pops;
        for (int c = 0; c < 500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = pick();
            in_b      = pick();
            in_sub    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (ST + 3) begin @(posedge clk); #1; end
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_some_pops", (n_pops - base) > 100, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
